video_dnn_argmax_count: RTL and testbench

Parametrised per-pixel classifier back end for the video DNN path. It sits behind the CNN core and converts the core's NUM_CLASS × CHANNEL_WIDTH binary clustering vector into three results: a winning class number, its vote count, and a delayed copy of the vector. It adds what the fixed 10-class/4-bit counter lacks: a fully parametrised class count and width, a rejection threshold, saturating width rules, and an optional per-frame class histogram.

---
 rtl/video_dnn_argmax_count.sv | 219 +++++++++++++++++++++
 tb/tb_video_dnn_argmax_count.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/video_dnn_argmax_count.sv
// Per-pixel class argmax with vote count, reject threshold and optional per-frame class histogram.
// Latency: 3 register stages (input beat, saturated popcounts, argmax/threshold); one beat per cycle.
// Backpressure: one common enable; a stalled output (valid && !ready) freezes every stage and drops s_axi4s_tready.
// Optional feature macro: VIDEO_DNN_ARGMAX_HIST_EN compiles in the per-frame histogram.
module video_dnn_argmax_count #(
    parameter int NUM_CLASS     = 10,
    parameter int CHANNEL_WIDTH = 8,
    parameter int TUSER_WIDTH   = 1,
    parameter int TNUMBER_WIDTH = 4,
    parameter int TCOUNT_WIDTH  = 4,
    parameter int HIST_WIDTH    = 16
) (
    input  logic                                  aclk,
    input  logic                                  aresetn,
    input  logic [TCOUNT_WIDTH-1:0]               param_th,
    input  logic [TUSER_WIDTH-1:0]                s_axi4s_tuser,
    input  logic                                  s_axi4s_tlast,
    input  logic [NUM_CLASS*CHANNEL_WIDTH-1:0]    s_axi4s_tdata,
    input  logic                                  s_axi4s_tvalid,
    output logic                                  s_axi4s_tready,
    output logic [TUSER_WIDTH-1:0]                m_axi4s_tuser,
    output logic                                  m_axi4s_tlast,
    output logic [TNUMBER_WIDTH-1:0]              m_axi4s_tnumber,
    output logic [TCOUNT_WIDTH-1:0]               m_axi4s_tcount,
    output logic [NUM_CLASS*CHANNEL_WIDTH-1:0]    m_axi4s_tdata,
    output logic                                  m_axi4s_tvalid,
    input  logic                                  m_axi4s_tready,
    output logic [NUM_CLASS*HIST_WIDTH-1:0]       hist_data,
    output logic                                  hist_valid
);

    localparam int DW   = NUM_CLASS * CHANNEL_WIDTH;
    localparam int CW   = NUM_CLASS * TCOUNT_WIDTH;
    localparam int CMAX = (1 << TCOUNT_WIDTH) - 1;

    // Saturating popcount of one class's vote bits.
    function automatic logic [TCOUNT_WIDTH-1:0] popcnt_sat(input logic [CHANNEL_WIDTH-1:0] v);
        int pc;
        pc = 0;
        for (int b = 0; b < CHANNEL_WIDTH; b++) begin
            pc = pc + int'(v[b]);
        end
        if (pc > CMAX) begin
            pc = CMAX;
        end
        return TCOUNT_WIDTH'(pc);
    endfunction

    logic                        cke;

    logic                        s1_vld_q;
    logic [DW-1:0]               s1_dat_q;
    logic [TUSER_WIDTH-1:0]      s1_user_q;
    logic                        s1_last_q;

    logic                        s2_vld_q;
    logic [DW-1:0]               s2_dat_q;
    logic [TUSER_WIDTH-1:0]      s2_user_q;
    logic                        s2_last_q;
    logic [CW-1:0]               s2_cnt_d;
    logic [CW-1:0]               s2_cnt_q;

    logic [TCOUNT_WIDTH-1:0]     best_cnt;
    logic [TNUMBER_WIDTH-1:0]    best_idx;
    logic [TNUMBER_WIDTH-1:0]    m_num_d;
    logic [TCOUNT_WIDTH-1:0]     m_cnt_d;

    logic                        m_vld_q;
    logic [DW-1:0]               m_dat_q;
    logic [TUSER_WIDTH-1:0]      m_user_q;
    logic                        m_last_q;
    logic [TNUMBER_WIDTH-1:0]    m_num_q;
    logic [TCOUNT_WIDTH-1:0]     m_cnt_q;

    // Whole pipeline moves together; bubbles are not squeezed out.
    assign cke            = !m_vld_q || m_axi4s_tready;
    assign s_axi4s_tready = cke;

    // Stage 1: capture the input beat and its sideband.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            s1_vld_q  <= 1'b0;
            s1_dat_q  <= '0;
            s1_user_q <= '0;
            s1_last_q <= 1'b0;
        end else if (cke) begin
            s1_vld_q  <= s_axi4s_tvalid;
            s1_dat_q  <= s_axi4s_tdata;
            s1_user_q <= s_axi4s_tuser;
            s1_last_q <= s_axi4s_tlast;
        end
    end

    // Per-class saturated vote counts.
    always_comb begin
        s2_cnt_d = '0;
        for (int c = 0; c < NUM_CLASS; c++) begin
            s2_cnt_d[c*TCOUNT_WIDTH +: TCOUNT_WIDTH] = popcnt_sat(s1_dat_q[c*CHANNEL_WIDTH +: CHANNEL_WIDTH]);
        end
    end

    // Stage 2: register counts alongside the beat.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            s2_vld_q  <= 1'b0;
            s2_dat_q  <= '0;
            s2_user_q <= '0;
            s2_last_q <= 1'b0;
            s2_cnt_q  <= '0;
        end else if (cke) begin
            s2_vld_q  <= s1_vld_q;
            s2_dat_q  <= s1_dat_q;
            s2_user_q <= s1_user_q;
            s2_last_q <= s1_last_q;
            s2_cnt_q  <= s2_cnt_d;
        end
    end

    // Argmax with strict compare so the lowest index wins ties, then the reject threshold.
    always_comb begin
        best_cnt = s2_cnt_q[0 +: TCOUNT_WIDTH];
        best_idx = '0;
        for (int c = 1; c < NUM_CLASS; c++) begin
            if (s2_cnt_q[c*TCOUNT_WIDTH +: TCOUNT_WIDTH] > best_cnt) begin
                best_cnt = s2_cnt_q[c*TCOUNT_WIDTH +: TCOUNT_WIDTH];
                best_idx = TNUMBER_WIDTH'(c);
            end
        end
        m_cnt_d = best_cnt;
        m_num_d = best_idx;
        if ((param_th != '0) && (best_cnt < param_th)) begin
            m_num_d = '1;
        end
    end

    // Stage 3: output register; holds while stalled.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            m_vld_q  <= 1'b0;
            m_dat_q  <= '0;
            m_user_q <= '0;
            m_last_q <= 1'b0;
            m_num_q  <= '0;
            m_cnt_q  <= '0;
        end else if (cke) begin
            m_vld_q  <= s2_vld_q;
            m_dat_q  <= s2_dat_q;
            m_user_q <= s2_user_q;
            m_last_q <= s2_last_q;
            m_num_q  <= m_num_d;
            m_cnt_q  <= m_cnt_d;
        end
    end

    assign m_axi4s_tvalid  = m_vld_q;
    assign m_axi4s_tdata   = m_dat_q;
    assign m_axi4s_tuser   = m_user_q;
    assign m_axi4s_tlast   = m_last_q;
    assign m_axi4s_tnumber = m_num_q;
    assign m_axi4s_tcount  = m_cnt_q;

`ifdef VIDEO_DNN_ARGMAX_HIST_EN
    logic                              out_hs;
    logic                              frame_start;
    logic                              is_rej;
    logic [NUM_CLASS*HIST_WIDTH-1:0]   hist_cnt_d;
    logic [NUM_CLASS*HIST_WIDTH-1:0]   hist_cnt_q;
    logic [NUM_CLASS*HIST_WIDTH-1:0]   hist_dat_q;
    logic                              hist_vld_q;
    logic                              frame_active_q;

    assign out_hs      = m_vld_q && m_axi4s_tready;
    assign frame_start = out_hs && m_user_q[0];
    assign is_rej      = (m_num_q == '1);

    // Next counter state: restart on frame start, then add this beat's vote unless rejected.
    always_comb begin
        hist_cnt_d = hist_cnt_q;
        if (frame_start) begin
            hist_cnt_d = '0;
        end
        if (out_hs && !is_rej) begin
            for (int c = 0; c < NUM_CLASS; c++) begin
                if ((TNUMBER_WIDTH'(c) == m_num_q) &&
                    (hist_cnt_d[c*HIST_WIDTH +: HIST_WIDTH] != {HIST_WIDTH{1'b1}})) begin
                    hist_cnt_d[c*HIST_WIDTH +: HIST_WIDTH] =
                        hist_cnt_d[c*HIST_WIDTH +: HIST_WIDTH] + HIST_WIDTH'(1);
                end
            end
        end
    end

    // Counters, publish strobe and the first-frame guard.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            hist_cnt_q     <= '0;
            hist_dat_q     <= '0;
            hist_vld_q     <= 1'b0;
            frame_active_q <= 1'b0;
        end else begin
            hist_cnt_q <= hist_cnt_d;
            hist_vld_q <= frame_start && frame_active_q;
            if (frame_start && frame_active_q) begin
                hist_dat_q <= hist_cnt_q;
            end
            if (frame_start) begin
                frame_active_q <= 1'b1;
            end
        end
    end

    assign hist_data  = hist_dat_q;
    assign hist_valid = hist_vld_q;
`else
    assign hist_data  = '0;
    assign hist_valid = 1'b0;
`endif

endmodule

// File: tb/tb_video_dnn_argmax_count.sv
// Directed and streamed checks of the argmax/count back end against hand-computed values and a small model.
// Latency: expects results three clock edges after the input is driven.
// Backpressure: random m_axi4s_tready in the stream phase; stalled outputs must hold.
module tb_video_dnn_argmax_count;

    localparam int NC = 10;
    localparam int CWD = 8;
    localparam int DW = NC * CWD;
    localparam int HW = 16;

    logic               aclk;
    logic               aresetn;
    logic [3:0]         param_th;
    logic [0:0]         s_axi4s_tuser;
    logic               s_axi4s_tlast;
    logic [DW-1:0]      s_axi4s_tdata;
    logic               s_axi4s_tvalid;
    logic               s_axi4s_tready;
    logic [0:0]         m_axi4s_tuser;
    logic               m_axi4s_tlast;
    logic [3:0]         m_axi4s_tnumber;
    logic [3:0]         m_axi4s_tcount;
    logic [DW-1:0]      m_axi4s_tdata;
    logic               m_axi4s_tvalid;
    logic               m_axi4s_tready;
    logic [NC*HW-1:0]   hist_data;
    logic               hist_valid;

    video_dnn_argmax_count dut (
        .aclk            (aclk),
        .aresetn         (aresetn),
        .param_th        (param_th),
        .s_axi4s_tuser   (s_axi4s_tuser),
        .s_axi4s_tlast   (s_axi4s_tlast),
        .s_axi4s_tdata   (s_axi4s_tdata),
        .s_axi4s_tvalid  (s_axi4s_tvalid),
        .s_axi4s_tready  (s_axi4s_tready),
        .m_axi4s_tuser   (m_axi4s_tuser),
        .m_axi4s_tlast   (m_axi4s_tlast),
        .m_axi4s_tnumber (m_axi4s_tnumber),
        .m_axi4s_tcount  (m_axi4s_tcount),
        .m_axi4s_tdata   (m_axi4s_tdata),
        .m_axi4s_tvalid  (m_axi4s_tvalid),
        .m_axi4s_tready  (m_axi4s_tready),
        .hist_data       (hist_data),
        .hist_valid      (hist_valid)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    typedef struct {
        logic [DW-1:0] dat;
        logic [3:0]    num;
        logic [3:0]    cnt;
        logic          user;
        logic          last;
    } exp_t;

    int            n_chk = 0;
    int            n_err = 0;
    int            npulse;
    int            nvalid;
    logic [NC*HW-1:0] hcap;
    exp_t          q[$];

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] vec1(input int c, input logic [7:0] b);
        logic [DW-1:0] v;
        v = '0;
        v[c*CWD +: CWD] = b;
        return v;
    endfunction

    // Reference: popcount per class, first maximum wins, reject below a nonzero threshold.
    function automatic logic [7:0] model(input logic [DW-1:0] d, input logic [3:0] th);
        int best;
        int idx;
        int p;
        logic [3:0] num;
        best = -1;
        idx  = 0;
        for (int c = 0; c < NC; c++) begin
            p = $countones(d[c*CWD +: CWD]);
            if (p > 15) p = 15;
            if (p > best) begin
                best = p;
                idx  = c;
            end
        end
        num = ((th != 4'd0) && (best < int'(th))) ? 4'hF : 4'(idx);
        return {num, 4'(best)};
    endfunction

    // One cycle: sample strobes produced by the previous edge, then drive the next input.
    task automatic tick(input logic v, input logic [DW-1:0] d, input logic u);
        @(negedge aclk);
        if (hist_valid) begin
            npulse++;
            hcap = hist_data;
        end
        if (m_axi4s_tvalid) nvalid++;
        s_axi4s_tvalid = v;
        s_axi4s_tdata  = d;
        s_axi4s_tuser  = u;
        s_axi4s_tlast  = u;
    endtask

    task automatic send_one(input string tag, input logic [DW-1:0] d, input logic [3:0] th,
                            input logic [3:0] en, input logic [3:0] ec);
        param_th       = th;
        m_axi4s_tready = 1'b1;
        tick(1'b1, d, 1'b1);
        tick(1'b0, '0, 1'b0);
        tick(1'b0, '0, 1'b0);
        chk({tag, "_early"}, 128'(m_axi4s_tvalid), 128'(0));
        tick(1'b0, '0, 1'b0);
        chk({tag, "_vld"},  128'(m_axi4s_tvalid),  128'(1));
        chk({tag, "_num"},  128'(m_axi4s_tnumber), 128'(en));
        chk({tag, "_cnt"},  128'(m_axi4s_tcount),  128'(ec));
        chk({tag, "_dat"},  128'(m_axi4s_tdata),   128'(d));
        chk({tag, "_user"}, 128'(m_axi4s_tuser),   128'(1));
    endtask

    task automatic do_reset(input int n);
        @(negedge aclk);
        aresetn = 1'b0;
        s_axi4s_tvalid = 1'b0;
        repeat (n) @(negedge aclk);
        aresetn = 1'b1;
    endtask

    initial begin
        logic [DW-1:0] d;
        logic [7:0]    r;
        exp_t          e;
        exp_t          sv;
        logic          acc_prev;
        logic          stall_prev;
        int            sent;
        int            rcvd;
        int            cyc;
        int            exp_h[NC];

        aresetn        = 1'b0;
        param_th       = '0;
        s_axi4s_tuser  = '0;
        s_axi4s_tlast  = 1'b0;
        s_axi4s_tdata  = '0;
        s_axi4s_tvalid = 1'b0;
        m_axi4s_tready = 1'b1;
        npulse = 0;
        nvalid = 0;
        hcap   = '0;
        do_reset(3);

        // reset state
        chk("rst_vld",   128'(m_axi4s_tvalid),  128'(0));
        chk("rst_num",   128'(m_axi4s_tnumber), 128'(0));
        chk("rst_cnt",   128'(m_axi4s_tcount),  128'(0));
        chk("rst_dat",   128'(m_axi4s_tdata),   128'(0));
        chk("rst_hvld",  128'(hist_valid),      128'(0));
        chk("rst_hdat",  128'(|hist_data),      128'(0));
        chk("rst_s_rdy", 128'(s_axi4s_tready),  128'(1));

        // directed vectors
        send_one("c3", vec1(3, 8'hFF), 4'd0, 4'd3, 4'd8);
        m_axi4s_tready = 1'b0;
        #1 chk("bp_s_rdy_low", 128'(s_axi4s_tready), 128'(0));
        tick(1'b0, '0, 1'b0);
        chk("bp_hold_vld", 128'(m_axi4s_tvalid),  128'(1));
        chk("bp_hold_num", 128'(m_axi4s_tnumber), 128'(3));
        m_axi4s_tready = 1'b1;
        #1 chk("bp_s_rdy_high", 128'(s_axi4s_tready), 128'(1));
        tick(1'b0, '0, 1'b0);
        chk("bp_drain", 128'(m_axi4s_tvalid), 128'(0));

        d = vec1(2, 8'h0F) | vec1(7, 8'h0F);
        send_one("tie",   d, 4'd0, 4'd2, 4'd4);
        send_one("th5",   d, 4'd5, 4'hF, 4'd4);
        send_one("th4",   d, 4'd4, 4'd2, 4'd4);
        send_one("zero",  '0, 4'd0, 4'd0, 4'd0);
        send_one("zth1",  '0, 4'd1, 4'hF, 4'd0);
        send_one("c9",    vec1(9, 8'hFF) | vec1(0, 8'h7F), 4'd0, 4'd9, 4'd8);

        // 100-beat stream with random output readiness
        param_th   = 4'd6;
        sent       = 0;
        rcvd       = 0;
        cyc        = 0;
        acc_prev   = 1'b0;
        stall_prev = 1'b0;
        sv         = '{default: '0};
        while (rcvd < 100 && cyc < 3000) begin
            @(negedge aclk);
            cyc++;
            if (stall_prev) begin
                chk("stall_vld", 128'(m_axi4s_tvalid),  128'(1));
                chk("stall_num", 128'(m_axi4s_tnumber), 128'(sv.num));
                chk("stall_cnt", 128'(m_axi4s_tcount),  128'(sv.cnt));
                chk("stall_dat", 128'(m_axi4s_tdata),   128'(sv.dat));
            end
            if (sent < 100 && (acc_prev || !s_axi4s_tvalid)) begin
                for (int c = 0; c < NC; c++) begin
                    r = 8'($urandom_range(0, 255));
                    d[c*CWD +: CWD] = r;
                end
                s_axi4s_tdata  = d;
                s_axi4s_tuser  = (sent == 0);
                s_axi4s_tlast  = (sent == 99);
                s_axi4s_tvalid = 1'b1;
            end else if (acc_prev) begin
                s_axi4s_tvalid = 1'b0;
            end
            m_axi4s_tready = 1'($urandom_range(0, 1));
            #1;
            chk("s_rdy", 128'(s_axi4s_tready), 128'(!m_axi4s_tvalid || m_axi4s_tready));
            acc_prev = s_axi4s_tvalid && s_axi4s_tready;
            if (acc_prev) begin
                {e.num, e.cnt} = model(s_axi4s_tdata, param_th);
                e.dat  = s_axi4s_tdata;
                e.user = s_axi4s_tuser[0];
                e.last = s_axi4s_tlast;
                q.push_back(e);
                sent++;
            end
            if (m_axi4s_tvalid && m_axi4s_tready) begin
                if (q.size() == 0) begin
                    chk("stream_extra", 128'(1), 128'(0));
                end else begin
                    e = q.pop_front();
                    chk("s_num",  128'(m_axi4s_tnumber), 128'(e.num));
                    chk("s_cnt",  128'(m_axi4s_tcount),  128'(e.cnt));
                    chk("s_dat",  128'(m_axi4s_tdata),   128'(e.dat));
                    chk("s_user", 128'(m_axi4s_tuser),   128'(e.user));
                    chk("s_last", 128'(m_axi4s_tlast),   128'(e.last));
                end
                rcvd++;
            end
            stall_prev = m_axi4s_tvalid && !m_axi4s_tready;
            sv.num = m_axi4s_tnumber;
            sv.cnt = m_axi4s_tcount;
            sv.dat = m_axi4s_tdata;
        end
        chk("stream_rcvd", 128'(rcvd), 128'(100));
        chk("stream_left", 128'(q.size()), 128'(0));
        s_axi4s_tvalid = 1'b0;
        m_axi4s_tready = 1'b1;

`ifdef VIDEO_DNN_ARGMAX_HIST_EN
        // per-frame histogram: frame 1 = classes 1,1,1,4,reject,9
        do_reset(1);
        param_th = 4'd1;
        npulse   = 0;
        hcap     = '0;
        tick(1'b1, vec1(1, 8'hFF), 1'b1);
        tick(1'b1, vec1(1, 8'hFF), 1'b0);
        tick(1'b1, vec1(1, 8'hFF), 1'b0);
        tick(1'b1, vec1(4, 8'hFF), 1'b0);
        tick(1'b1, '0,             1'b0);
        tick(1'b1, vec1(9, 8'hFF), 1'b0);
        tick(1'b1, vec1(1, 8'hFF), 1'b1);
        repeat (8) tick(1'b0, '0, 1'b0);
        chk("hist_pulses", 128'(npulse), 128'(1));
        for (int c = 0; c < NC; c++) exp_h[c] = 0;
        exp_h[1] = 3;
        exp_h[4] = 1;
        exp_h[9] = 1;
        for (int c = 0; c < NC; c++) begin
            chk($sformatf("hist_c%0d", c), 128'(hcap[c*HW +: HW]), 128'(exp_h[c]));
        end
`else
        chk("nohist_vld", 128'(hist_valid), 128'(0));
        chk("nohist_dat", 128'(|hist_data), 128'(0));
`endif

        // reset mid-frame with two beats in flight
        param_th = 4'd0;
        tick(1'b1, vec1(2, 8'hFF), 1'b1);
        tick(1'b1, vec1(3, 8'hFF), 1'b0);
        @(negedge aclk);
        aresetn        = 1'b0;
        s_axi4s_tvalid = 1'b0;
        @(negedge aclk);
        aresetn = 1'b1;
        chk("mrst_vld",  128'(m_axi4s_tvalid),  128'(0));
        chk("mrst_num",  128'(m_axi4s_tnumber), 128'(0));
        chk("mrst_cnt",  128'(m_axi4s_tcount),  128'(0));
        chk("mrst_dat",  128'(m_axi4s_tdata),   128'(0));
        chk("mrst_user", 128'(m_axi4s_tuser),   128'(0));
        chk("mrst_hvld", 128'(hist_valid),      128'(0));
        chk("mrst_hdat", 128'(|hist_data),      128'(0));
        nvalid = 0;
        repeat (5) tick(1'b0, '0, 1'b0);
        chk("mrst_flushed", 128'(nvalid), 128'(0));
        npulse = 0;
        nvalid = 0;
        tick(1'b1, vec1(5, 8'hFF), 1'b1);
        repeat (8) tick(1'b0, '0, 1'b0);
        chk("mrst_no_pub", 128'(npulse), 128'(0));
        chk("mrst_new_beat", 128'(nvalid), 128'(1));

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
